flash_mem_responder: RTL and testbench

Avalon-MM pipelined-read slave that models the on-board flash memory port, i.e. the responder end of the flash_mem read interface driven by the audio flash player. It accepts read commands with bursts, returns a deterministic address-derived data pattern after a fixed latency, and can inject bubble cycles. It replaces the flash IP in simulation and in FPGA bring-up builds, so initiator FSMs can be exercised without programmed flash.

---
 rtl/flash_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_flash_mem_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : flash_mem_responder
// Brief    : Avalon-MM pipelined-read slave standing in for the flash port.
//            Serves bursts of {~A[15:0], A[15:0]} after a fixed latency, with
//            optional bubble cycles, and discards writes while counting them.
// Revision : 1.0 - initial release
// ============================================================================
module flash_mem_responder #(
    parameter int ADDR_WIDTH   = 23,
    parameter int BURST_WIDTH  = 6,
    parameter int READ_LATENCY = 2,
    parameter int BOOT_CYCLES  = 4,
    parameter int STALL_EVERY  = 0
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   flash_mem_read,
    input  logic                   flash_mem_write,
    input  logic [ADDR_WIDTH-1:0]  flash_mem_address,
    input  logic [BURST_WIDTH-1:0] flash_mem_burstcount,
    input  logic [3:0]             flash_mem_byteenable,
    input  logic [31:0]            flash_mem_writedata,
    output logic                   flash_mem_waitrequest,
    output logic [31:0]            flash_mem_readdata,
    output logic                   flash_mem_readdatavalid,
    output logic                   busy,
    output logic [7:0]             writes_dropped
);

    localparam logic [2:0] S_BOOT    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_LATENCY = 3'd2;
    localparam logic [2:0] S_STREAM  = 3'd3;
    localparam logic [2:0] S_BUBBLE  = 3'd4;

    // Terminal counts; the latency state covers READ_LATENCY-1 cycles because
    // the accept cycle itself is the first cycle of latency.
    localparam logic [15:0] c_boot_last   = (BOOT_CYCLES > 0) ? 16'(BOOT_CYCLES - 1) : 16'd0;
    localparam logic [3:0]  c_lat_last    = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;
    localparam logic [7:0]  c_stall_every = 8'(STALL_EVERY);
    localparam logic [BURST_WIDTH-1:0] c_one_beat = BURST_WIDTH'(1);

    logic [2:0]             r_state;
    logic [2:0]             w_next_state;
    logic [15:0]            r_boot_cnt;
    logic [3:0]             r_lat_cnt;
    logic [7:0]             r_stall_cnt;
    logic [BURST_WIDTH-1:0] r_beats_left;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_waitrequest;
    logic [7:0]             r_writes_dropped;

    logic w_accept;
    logic w_last_beat;
    logic w_stall_hit;
    logic w_unused;

    // Payload and byte lanes of writes are never stored.
    assign w_unused = ^{flash_mem_byteenable, flash_mem_writedata};

    assign w_accept    = (r_state == S_IDLE) && flash_mem_read;
    assign w_last_beat = (r_beats_left == c_one_beat);
    assign w_stall_hit = (c_stall_every != 8'd0) && ((r_stall_cnt + 8'd1) == c_stall_every);

    // State register; reset aborts any burst in flight and restarts boot.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decision.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_BOOT: begin
                if (r_boot_cnt == c_boot_last) begin
                    w_next_state = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (READ_LATENCY <= 1) ? S_STREAM : S_LATENCY;
                end
            end
            S_LATENCY: begin
                if (r_lat_cnt == c_lat_last) begin
                    w_next_state = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_last_beat) begin
                    w_next_state = S_IDLE;
                end else if (w_stall_hit) begin
                    w_next_state = S_BUBBLE;
                end
            end
            S_BUBBLE: begin
                w_next_state = S_STREAM;
            end
            default: begin
                w_next_state = S_BOOT;
            end
        endcase
    end

    // Counters, captured command and registered waitrequest.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_boot_cnt       <= 16'd0;
            r_lat_cnt        <= 4'd0;
            r_stall_cnt      <= 8'd0;
            r_beats_left     <= '0;
            r_addr           <= '0;
            r_waitrequest    <= 1'b1;
            r_writes_dropped <= 8'd0;
        end else begin
            r_waitrequest <= (w_next_state != S_IDLE);
            case (r_state)
                S_BOOT: begin
                    r_boot_cnt <= r_boot_cnt + 16'd1;
                end
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr       <= flash_mem_address;
                        r_beats_left <= (flash_mem_burstcount == '0) ? c_one_beat
                                                                     : flash_mem_burstcount;
                        r_lat_cnt    <= 4'd0;
                        r_stall_cnt  <= 8'd0;
                    end
                    if (flash_mem_write && (r_writes_dropped != 8'hFF)) begin
                        r_writes_dropped <= r_writes_dropped + 8'd1;
                    end
                end
                S_LATENCY: begin
                    r_lat_cnt <= r_lat_cnt + 4'd1;
                end
                S_STREAM: begin
                    r_addr       <= r_addr + ADDR_WIDTH'(1);
                    r_beats_left <= r_beats_left - c_one_beat;
                    r_stall_cnt  <= w_stall_hit ? 8'd0 : (r_stall_cnt + 8'd1);
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from the current state; data is forced to 0 off-beat.
    always_comb begin
        busy                    = (r_state != S_IDLE);
        flash_mem_readdatavalid = (r_state == S_STREAM);
        flash_mem_readdata      = 32'd0;
        if (r_state == S_STREAM) begin
            flash_mem_readdata = {~r_addr[15:0], r_addr[15:0]};
        end
        flash_mem_waitrequest   = r_waitrequest;
        writes_dropped          = r_writes_dropped;
    end

endmodule
`default_nettype wire

// File: tb/tb_flash_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_mem_responder
// Brief    : Self-checking bench for flash_mem_responder. Beat data is
//            checked against a queue of expected words; timing is checked as
//            per-cycle valid/waitrequest bit patterns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flash_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetb;

    // Default instance (no bubbles)
    logic        rd0, wr0;
    logic [22:0] addr0;
    logic [5:0]  bc0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic        wreq0, rvalid0, busy0;
    logic [31:0] rdata0;
    logic [7:0]  wcnt0;

    // Bubble instance (STALL_EVERY = 2)
    logic        rd1, wr1;
    logic [22:0] addr1;
    logic [5:0]  bc1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic        wreq1, rvalid1, busy1;
    logic [31:0] rdata1;
    logic [7:0]  wcnt1;

    flash_mem_responder #(.STALL_EVERY(0)) u_dut0 (
        .clk                     (clk),
        .resetb                  (resetb),
        .flash_mem_read          (rd0),
        .flash_mem_write         (wr0),
        .flash_mem_address       (addr0),
        .flash_mem_burstcount    (bc0),
        .flash_mem_byteenable    (be0),
        .flash_mem_writedata     (wd0),
        .flash_mem_waitrequest   (wreq0),
        .flash_mem_readdata      (rdata0),
        .flash_mem_readdatavalid (rvalid0),
        .busy                    (busy0),
        .writes_dropped          (wcnt0)
    );

    flash_mem_responder #(.STALL_EVERY(2)) u_dut1 (
        .clk                     (clk),
        .resetb                  (resetb),
        .flash_mem_read          (rd1),
        .flash_mem_write         (wr1),
        .flash_mem_address       (addr1),
        .flash_mem_burstcount    (bc1),
        .flash_mem_byteenable    (be1),
        .flash_mem_writedata     (wd1),
        .flash_mem_waitrequest   (wreq1),
        .flash_mem_readdata      (rdata1),
        .flash_mem_readdatavalid (rvalid1),
        .busy                    (busy1),
        .writes_dropped          (wcnt1)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] m_exp0, m_exp1;

    function automatic logic [31:0] pat(input logic [22:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // Scoreboard for instance 0: every beat pops one expected word.
    always @(negedge clk) begin
        n_checks++;
        if (rvalid0) begin
            if (q0.size() == 0) begin
                n_errors++;
                $display("FAIL dut0_beat: unexpected beat readdata=%h, required no beat", rdata0);
            end else begin
                m_exp0 = q0.pop_front();
                if (rdata0 !== m_exp0) begin
                    n_errors++;
                    $display("FAIL dut0_beat: readdata=%h required=%h", rdata0, m_exp0);
                end
            end
        end else if (rdata0 !== 32'd0) begin
            n_errors++;
            $display("FAIL dut0_idle_data: readdata=%h required=00000000", rdata0);
        end
    end

    // Scoreboard for instance 1.
    always @(negedge clk) begin
        n_checks++;
        if (rvalid1) begin
            if (q1.size() == 0) begin
                n_errors++;
                $display("FAIL dut1_beat: unexpected beat readdata=%h, required no beat", rdata1);
            end else begin
                m_exp1 = q1.pop_front();
                if (rdata1 !== m_exp1) begin
                    n_errors++;
                    $display("FAIL dut1_beat: readdata=%h required=%h", rdata1, m_exp1);
                end
            end
        end else if (rdata1 !== 32'd0) begin
            n_errors++;
            $display("FAIL dut1_idle_data: readdata=%h required=00000000", rdata1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits (bounded) at negedges until instance 0 can accept a command.
    task automatic wait_idle0();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (wreq0 === 1'b0) ok = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL wait_idle0: waitrequest=%b required 0 within 200 cycles", wreq0);
        end
    endtask

    // Issues one command in cycle T and returns at the negedge of T+1.
    task automatic start_read0(input logic [22:0] a, input logic [5:0] bc, input logic with_write);
        int n;
        wait_idle0();
        rd0   = 1'b1;
        wr0   = with_write;
        addr0 = a;
        bc0   = bc;
        be0   = 4'($urandom);
        wd0   = $urandom;
        n = (bc == 6'd0) ? 1 : int'(bc);
        for (int i = 0; i < n; i++) q0.push_back(pat(a + 23'(i)));
        @(negedge clk);
        rd0   = 1'b0;
        wr0   = 1'b0;
        addr0 = 23'($urandom);
        bc0   = 6'($urandom);
    endtask

    // Records n cycles of valid/waitrequest, first sample ends up leftmost.
    task automatic sample0(input int n, output logic [15:0] vp, output logic [15:0] wp);
        vp = '0;
        wp = '0;
        for (int i = 0; i < n; i++) begin
            vp = {vp[14:0], rvalid0};
            wp = {wp[14:0], wreq0};
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [15:0] vp, wp;
        resetb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (wreq0 !== 1'b1) begin n_errors++; $display("FAIL reset_waitreq: got %b required 1", wreq0); end
        n_checks++; if (rvalid0 !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b required 0", rvalid0); end
        n_checks++; if (busy0 !== 1'b1) begin n_errors++; $display("FAIL reset_busy: got %b required 1", busy0); end
        n_checks++; if (wcnt0 !== 8'd0) begin n_errors++; $display("FAIL reset_wcnt: got %0d required 0", wcnt0); end
        resetb = 1'b1;
        @(negedge clk);
        sample0(5, vp, wp);
        n_checks++; if (wp !== 16'b11100) begin n_errors++; $display("FAIL boot_waitreq: pattern %b required 11100", wp[4:0]); end
        n_checks++; if (vp !== 16'b0) begin n_errors++; $display("FAIL boot_valid: pattern %b required 00000", vp[4:0]); end
        n_checks++; if (busy0 !== 1'b0) begin n_errors++; $display("FAIL boot_busy: got %b required 0", busy0); end
        n_checks++; if (wreq1 !== 1'b0) begin n_errors++; $display("FAIL boot_waitreq1: got %b required 0", wreq1); end
    endtask

    task automatic test_single();
        logic [15:0] vp, wp;
        start_read0(23'h000000, 6'd1, 1'b0);
        sample0(3, vp, wp);
        n_checks++; if (vp !== 16'b010) begin n_errors++; $display("FAIL single_valid: pattern %b required 010", vp[2:0]); end
        n_checks++; if (wp !== 16'b110) begin n_errors++; $display("FAIL single_waitreq: pattern %b required 110", wp[2:0]); end
    endtask

    task automatic test_burst();
        logic [15:0] vp, wp;
        start_read0(23'h000005, 6'd4, 1'b0);
        sample0(6, vp, wp);
        n_checks++; if (vp !== 16'b011110) begin n_errors++; $display("FAIL burst4_valid: pattern %b required 011110", vp[5:0]); end
        n_checks++; if (wp !== 16'b111110) begin n_errors++; $display("FAIL burst4_waitreq: pattern %b required 111110", wp[5:0]); end
        start_read0(23'h000005, 6'd0, 1'b0);
        sample0(3, vp, wp);
        n_checks++; if (vp !== 16'b010) begin n_errors++; $display("FAIL burst0_valid: pattern %b required 010", vp[2:0]); end
    endtask

    task automatic test_wrap();
        logic [15:0] vp, wp;
        start_read0(23'h7FFFFF, 6'd2, 1'b0);
        sample0(4, vp, wp);
        n_checks++; if (vp !== 16'b0110) begin n_errors++; $display("FAIL wrap_valid: pattern %b required 0110", vp[3:0]); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vp, wp;
        start_read0(23'h000020, 6'd2, 1'b0);
        sample0(3, vp, wp);
        n_checks++; if (wp !== 16'b111) begin n_errors++; $display("FAIL b2b_first_waitreq: pattern %b required 111", wp[2:0]); end
        n_checks++; if (wreq0 !== 1'b0) begin n_errors++; $display("FAIL b2b_idle: waitrequest=%b required 0", wreq0); end
        start_read0(23'h000040, 6'd3, 1'b0);
        sample0(5, vp, wp);
        n_checks++; if (vp !== 16'b01110) begin n_errors++; $display("FAIL b2b_second_valid: pattern %b required 01110", vp[4:0]); end
    endtask

    task automatic test_writes();
        logic [15:0] vp, wp;
        start_read0(23'h000003, 6'd1, 1'b1);
        sample0(3, vp, wp);
        n_checks++; if (vp !== 16'b010) begin n_errors++; $display("FAIL rw_valid: pattern %b required 010", vp[2:0]); end
        n_checks++; if (wcnt0 !== 8'd1) begin n_errors++; $display("FAIL rw_wcnt: got %0d required 1", wcnt0); end
        wait_idle0();
        wr0 = 1'b1;
        repeat (10) @(negedge clk);
        wr0 = 1'b0;
        n_checks++; if (wcnt0 !== 8'd11) begin n_errors++; $display("FAIL write_count: got %0d required 11", wcnt0); end
        wr0 = 1'b1;
        repeat (290) @(negedge clk);
        wr0 = 1'b0;
        n_checks++; if (wcnt0 !== 8'd255) begin n_errors++; $display("FAIL write_saturate: got %0d required 255", wcnt0); end
        n_checks++; if (busy0 !== 1'b0) begin n_errors++; $display("FAIL write_busy: got %b required 0", busy0); end
    endtask

    task automatic test_stall();
        logic [15:0] vp;
        n_checks++; if (wreq1 !== 1'b0) begin n_errors++; $display("FAIL stall_ready: waitrequest=%b required 0", wreq1); end
        rd1   = 1'b1;
        addr1 = 23'h000000;
        bc1   = 6'd5;
        for (int i = 0; i < 5; i++) q1.push_back(pat(23'(i)));
        @(negedge clk);
        rd1   = 1'b0;
        addr1 = 23'($urandom);
        bc1   = 6'($urandom);
        vp = '0;
        for (int i = 0; i < 9; i++) begin
            vp = {vp[14:0], rvalid1};
            @(negedge clk);
        end
        n_checks++; if (vp !== 16'b011011010) begin n_errors++; $display("FAIL stall_valid: pattern %b required 011011010", vp[8:0]); end
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] vp, wp;
        start_read0(23'h000010, 6'd4, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 resetb = 1'b0;
        #1;
        n_checks++; if (rvalid0 !== 1'b0) begin n_errors++; $display("FAIL abort_valid: got %b required 0", rvalid0); end
        n_checks++; if (wreq0 !== 1'b1) begin n_errors++; $display("FAIL abort_waitreq: got %b required 1", wreq0); end
        n_checks++; if (q0.size() != 2) begin n_errors++; $display("FAIL abort_beats_before: remaining %0d required 2", q0.size()); end
        q0.delete();
        @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        sample0(8, vp, wp);
        n_checks++; if (wp !== 16'b11100000) begin n_errors++; $display("FAIL abort_boot: pattern %b required 11100000", wp[7:0]); end
        n_checks++; if (vp !== 16'b0) begin n_errors++; $display("FAIL abort_no_beats: pattern %b required 00000000", vp[7:0]); end
    endtask

    initial begin
        resetb = 1'b1;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; bc0 = '0; be0 = '0; wd0 = '0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; bc1 = '0; be1 = '0; wd1 = '0;
        #1 resetb = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_burst();
        test_wrap();
        test_back_to_back();
        test_writes();
        test_stall();
        test_reset_mid_burst();
        repeat (4) @(negedge clk);
        n_checks++; if (q0.size() != 0) begin n_errors++; $display("FAIL dut0_drain: %0d beats missing", q0.size()); end
        n_checks++; if (q1.size() != 0) begin n_errors++; $display("FAIL dut1_drain: %0d beats missing", q1.size()); end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
